// File: rtl/fetch_top.sv
// Instruction fetch stage: issues one memory read at a time, buffers a word while
// decode is stalled, and turns branch/jump redirects into NOP bubbles for decode.
//
// state | meaning
// ------+----------------------------------------------------------------
// REQ   | read of fetch_pc outstanding; next ack delivers or buffers it
// HOLD  | word captured while decode stalled; no memory request
// DROP  | squashed read still outstanding; its data is discarded on ack
module fetch_top #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        is_jump,
    input  logic [31:0] jump_addr,
    input  logic        branch,
    input  logic [31:0] branch_addr,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_data,
    output logic [31:0] pc,
    output logic [31:0] instruction,
    output logic        we
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_HOLD = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] pend_q, pend_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        we_q, we_d;

    logic        redir;
    logic [31:0] target;
    logic [31:0] fetch_pc_inc;

    // A branch from M outranks a jump from decode; a stalled decode cannot jump.
    assign redir        = branch | (is_jump & ~stall);
    assign target       = branch ? branch_addr : jump_addr;
    assign fetch_pc_inc = fetch_pc_q + 32'd4;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_REQ;
            fetch_pc_q   <= RESET_PC;
            pend_q       <= 32'h0;
            hold_pc_q    <= 32'h0;
            hold_instr_q <= 32'h0;
            pc_q         <= RESET_PC;
            instr_q      <= NOP_INSTR;
            we_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            pend_q       <= pend_d;
            hold_pc_q    <= hold_pc_d;
            hold_instr_q <= hold_instr_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            we_q         <= we_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_REQ: begin
                if (redir)
                    state_d = mem_ack ? S_REQ : S_DROP;
                else if (mem_ack && stall)
                    state_d = S_HOLD;
            end
            S_HOLD: begin
                if (redir || !stall)
                    state_d = S_REQ;
            end
            S_DROP: begin
                if (mem_ack)
                    state_d = S_REQ;
            end
            default: state_d = S_REQ;
        endcase
    end

    always_comb begin
        fetch_pc_d   = fetch_pc_q;
        pend_d       = pend_q;
        hold_pc_d    = hold_pc_q;
        hold_instr_d = hold_instr_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        we_d         = 1'b0;

        if (redir && !stall) begin
            pc_d    = target;
            instr_d = NOP_INSTR;
            we_d    = 1'b1;
        end

        case (state_q)
            S_REQ: begin
                if (redir) begin
                    // mem_addr must not move mid-request, so park the target.
                    if (mem_ack)
                        fetch_pc_d = target;
                    else
                        pend_d = target;
                end else if (mem_ack) begin
                    if (!stall) begin
                        pc_d       = fetch_pc_q;
                        instr_d    = mem_data;
                        we_d       = 1'b1;
                        fetch_pc_d = fetch_pc_inc;
                    end else begin
                        hold_pc_d    = fetch_pc_q;
                        hold_instr_d = mem_data;
                    end
                end
            end
            S_HOLD: begin
                if (redir) begin
                    fetch_pc_d = target;
                end else if (!stall) begin
                    pc_d       = hold_pc_q;
                    instr_d    = hold_instr_q;
                    we_d       = 1'b1;
                    fetch_pc_d = fetch_pc_inc;
                end
            end
            S_DROP: begin
                if (mem_ack)
                    fetch_pc_d = redir ? target : pend_q;
                else if (redir)
                    pend_d = target;
            end
            default: ;
        endcase
    end

    always_comb begin
        mem_req     = (state_q != S_HOLD);
        mem_addr    = fetch_pc_q;
        pc          = pc_q;
        instruction = instr_q;
        we          = we_q;
    end

endmodule

// File: doc/fetch_top.md
FETCH_TOP -- requirements
Module: fetch_top

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter NOP_INSTR, 32'h0000_0000, bubble instruction sent to decode on squash.
REQ-003 clk  in  1  rising-edge clock, sole clock of block.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 stall  in  1  hazard hold from decode; decode must not load a new instruction.
REQ-006 is_jump  in  1  decode has a jump in its register.
REQ-007 jump_addr  in  32  jump target from decode.
REQ-008 branch  in  1  taken-branch redirect from M stage.
REQ-009 branch_addr  in  32  branch target from M stage.
REQ-010 mem_req  out  1  instruction memory read request.
REQ-011 mem_addr  out  32  instruction memory read address.
REQ-012 mem_ack  in  1  read data valid this cycle; completes the request.
REQ-013 mem_data  in  32  instruction word, valid only with mem_ack.
REQ-014 pc  out  32  registered PC of the instruction presented to decode.
REQ-015 instruction  out  32  registered instruction presented to decode.
REQ-016 we  out  1  registered load strobe for decode's pipeline register.

Function
REQ-017 States: REQ (request outstanding), HOLD (word captured, decode stalled), DROP (squashed request still outstanding).
REQ-018 fetch_pc register holds the next address; mem_addr = fetch_pc; mem_req = 1 in REQ and DROP, 0 in HOLD.
REQ-019 mem_addr stays constant while mem_req=1 and mem_ack=0; a redirect never changes mem_addr mid-request.
REQ-020 Redirect priority: branch > is_jump > sequential; is_jump honoured only when stall=0; branch honoured regardless of stall.
REQ-021 REQ, mem_ack=1, no redirect, stall=0: pc<=fetch_pc, instruction<=mem_data, we<=1, fetch_pc<=fetch_pc+4, stay REQ (one word per ack, latency 1 cycle after ack).
REQ-022 REQ, mem_ack=1, no redirect, stall=1: word and its PC captured in hold buffer, we<=0, go HOLD.
REQ-023 HOLD, stall=0, no redirect: pc/instruction<=hold buffer, we<=1, fetch_pc<=fetch_pc+4, go REQ.
REQ-024 HOLD, stall=1: we<=0, outputs unchanged, stay HOLD.
REQ-025 Redirect in REQ with mem_ack=1 or in HOLD: fetch_pc<=target, captured/held word discarded, go REQ.
REQ-026 Redirect in REQ with mem_ack=0: target latched into fetch_pc-pending register, go DROP; mem_addr unchanged.
REQ-027 DROP: on mem_ack, data discarded, fetch_pc<=pending target, go REQ; a further redirect in DROP overwrites the pending target (later redirect wins).
REQ-028 Every accepted redirect with stall=0: instruction<=NOP_INSTR, pc<=target, we<=1 (bubble into decode); with stall=1: we<=0.
REQ-029 fetch_pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000), no flag.
REQ-030 we is a single-cycle pulse per delivered instruction or bubble; never 1 while stall=1.

Reset
REQ-031 reset=1 at a clock edge: state<=REQ, fetch_pc<=RESET_PC, pc<=RESET_PC, instruction<=NOP_INSTR, we<=0, hold buffer and pending target cleared.
REQ-032 reset overrides all other inputs; mem_ack arriving in the reset cycle is discarded.
REQ-033 First cycle after reset: mem_req=1, mem_addr=RESET_PC.

Verification
REQ-034 Reset, mem_ack every cycle with data=addr, stall=0 -> we=1 each cycle, pc 0,4,8,..., instruction equals pc.
REQ-035 Ack 3 cycles after each request -> mem_addr stable 3 cycles, one we pulse per ack, pc increments by 4.
REQ-036 stall=1 for 4 cycles across an ack at addr 0x10 -> state HOLD, mem_req=0, we=0; on release, pc=0x10 delivered with we=1, next mem_addr=0x14.
REQ-037 branch=1, branch_addr=0x200 while request to 0x20 pending (ack 2 cycles later) -> mem_addr stays 0x20, word discarded, bubble NOP with pc=0x200, next mem_addr=0x200.
REQ-038 branch=1 (0x300) and is_jump=1 (0x400) same cycle -> fetch_pc=0x300; is_jump=1 with stall=1 -> ignored.
REQ-039 fetch_pc=0xFFFF_FFFC, ack -> next mem_addr=0x0000_0000; reset asserted in DROP -> mem_addr=RESET_PC next cycle, we=0.
